// File: rtl/alu_md_unit.sv
// Execute-stage ALU with an iterative multiply/divide unit and a HI/LO register pair.
// The ALU is combinational; MD ops run over WIDTH/BITS_PER_CYC cycles plus one fix-up cycle.
module alu_md_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SHAMT_W      = 5,
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  output logic             ovf,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N_ITER = WIDTH / BITS_PER_CYC;
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } md_state_e;

  // ---------------------------------------------------------------- ALU
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [15:0]        b_lo16;

  assign shamt  = src_a[SHAMT_W-1:0];
  assign sum    = src_a + src_b;
  assign diff   = src_a - src_b;
  assign b_lo16 = 16'(src_b);

  always_comb begin
    alu_out = '0;
    ovf     = 1'b0;
    case (alu_op)
      4'd0: begin
        alu_out = sum;
        ovf     = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'd1: begin
        alu_out = diff;
        ovf     = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'd2:  alu_out = src_a | src_b;
      4'd3:  alu_out = src_b >> shamt;
      4'd4:  alu_out = src_b << shamt;
      4'd5:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'd6:  alu_out = src_a & src_b;
      4'd7:  alu_out = src_a ^ src_b;
      4'd8:  alu_out = $signed(src_b) >>> shamt;
      4'd9:  alu_out = WIDTH'($signed(b_lo16));
      4'd10: alu_out = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      4'd11: alu_out = ~(src_a | src_b);
      4'd12: alu_out = WIDTH'({b_lo16, 16'h0000});
      default: alu_out = '0;
    endcase
  end

  // ---------------------------------------------------------------- MD unit
  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               md_accept;
  logic               md_move;
  logic               in_signed;
  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     step_v;
  logic [WIDTH-1:0]   acc_v;
  logic [WIDTH-1:0]   work_v;
  logic [WIDTH-1:0]   rem_v;
  logic [WIDTH-1:0]   quo_v;
  logic [2*WIDTH-1:0] prod_v;

  // MULT/MULTU/DIV/DIVU are ops 0-3; MTHI/MTLO use the idle-only move path.
  assign md_accept = md_start && !md_flush && (md_op[2] == 1'b0);
  assign md_move   = md_start && !md_flush && (state_q == S_IDLE);
  assign in_signed = !md_op[0];
  assign in_neg_a  = in_signed && src_a[WIDTH-1];
  assign in_neg_b  = in_signed && src_b[WIDTH-1];
  assign mag_a     = in_neg_a ? -src_a : src_a;
  assign mag_b     = in_neg_b ? -src_b : src_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_accept) state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (md_flush) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    work_d   = work_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    step_v   = '0;
    acc_v    = acc_q;
    work_v   = work_q;
    rem_v    = '0;
    quo_v    = '0;
    prod_v   = '0;
    case (state_q)
      S_IDLE: begin
        if (md_accept) begin
          cnt_d    = '0;
          acc_d    = '0;
          work_d   = mag_a;
          opb_d    = mag_b;
          is_div_d = md_op[1];
          neg_a_d  = in_neg_a;
          neg_b_d  = in_neg_b;
          div0_d   = (src_b == '0);
        end else if (md_move && md_op == 3'd4) begin
          hi_d = src_a;
        end else if (md_move && md_op == 3'd5) begin
          lo_d = src_a;
        end
      end
      S_RUN: begin
        // Divide: restoring shift-subtract, quotient shifts into work.
        // Multiply: shift-add with the multiplier consumed from work's LSB.
        for (int unsigned k = 0; k < BITS_PER_CYC; k++) begin
          if (is_div_q) begin
            step_v = {acc_v, work_v[WIDTH-1]};
            work_v = {work_v[WIDTH-2:0], 1'b0};
            if (step_v >= {1'b0, opb_q}) begin
              step_v    = step_v - {1'b0, opb_q};
              work_v[0] = 1'b1;
            end
            acc_v = step_v[WIDTH-1:0];
          end else begin
            step_v = {1'b0, acc_v} + (work_v[0] ? {1'b0, opb_q} : '0);
            work_v = {step_v[0], work_v[WIDTH-1:1]};
            acc_v  = step_v[WIDTH:1];
          end
        end
        acc_d  = acc_v;
        work_d = work_v;
        cnt_d  = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        if (!md_flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Remainder follows the dividend's sign; on divide-by-zero it is the dividend.
            rem_v = neg_a_q ? -acc_q : acc_q;
            quo_v = (neg_a_q ^ neg_b_q) ? -work_q : work_q;
            hi_d  = rem_v;
            lo_d  = div0_q ? '1 : quo_v;
          end else begin
            prod_v = {acc_q, work_q};
            if (neg_a_q ^ neg_b_q) prod_v = -prod_v;
            hi_d = prod_v[2*WIDTH-1:WIDTH];
            lo_d = prod_v[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign md_busy = busy_q;
  assign md_done = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: arithmetic reference model compared every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_alu_md_unit;

  localparam int unsigned N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] src_a, src_b, alu_out, hi, lo;
  logic [3:0]  alu_op;
  logic        ovf, md_start, md_flush, md_busy, md_done;
  logic [2:0]  md_op;

  logic [15:0] s_a, s_b, s_alu, s_hi, s_lo;
  logic [3:0]  s_alu_op;
  logic        s_ovf, s_start, s_busy, s_done;
  logic [2:0]  s_op;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  alu_md_unit #(.WIDTH(32), .SHAMT_W(5), .BITS_PER_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .src_a(src_a), .src_b(src_b), .alu_op(alu_op),
    .alu_out(alu_out), .ovf(ovf), .md_start(md_start), .md_op(md_op),
    .md_flush(md_flush), .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
  );

  alu_md_unit #(.WIDTH(16), .SHAMT_W(4), .BITS_PER_CYC(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .src_a(s_a), .src_b(s_b), .alu_op(s_alu_op),
    .alu_out(s_alu), .ovf(s_ovf), .md_start(s_start), .md_op(s_op),
    .md_flush(1'b0), .md_busy(s_busy), .md_done(s_done), .hi(s_hi), .lo(s_lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ALU: plain integer arithmetic; overflow = true sum does not fit in 32 bits.
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic v);
    logic [31:0] r;
    longint      s;
    longint      sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    v  = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd1: begin s = sa - sb; r = 32'(s); v = (s != longint'($signed(r))); end
      4'd2:  r = a | b;
      4'd3:  r = b >> a[4:0];
      4'd4:  r = b << a[4:0];
      4'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  r = a & b;
      4'd7:  r = a ^ b;
      4'd8:  r = $signed(b) >>> a[4:0];
      4'd9:  r = {{16{b[15]}}, b[15:0]};
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: r = ~(a | b);
      4'd12: r = {b[15:0], 16'h0000};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reference MD result {hi, lo}.
  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Cycle-level expectations of the MD handshake.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  logic [63:0] m_pend;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (md_flush) begin
        m_busy = 1'b0;
        m_left = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_hi, m_lo} = m_pend;
        end
      end else if (md_start) begin
        if (md_op <= 3'd3) begin
          m_pend = md_model(md_op, src_a, src_b);
          m_busy = 1'b1;
          m_left = N + 1;
        end else if (md_op == 3'd4) m_hi = src_a;
        else if (md_op == 3'd5) m_lo = src_a;
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] ea;
    logic        eo;
    #3;
    if (cmp_en) begin
      ea = alu_model(alu_op, src_a, src_b, eo);
      check("cyc_alu_out", 64'(alu_out), 64'(ea));
      check("cyc_ovf", 64'(ovf), 64'(eo));
      check("cyc_md_busy", 64'(md_busy), 64'(m_busy));
      check("cyc_md_done", 64'(md_done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic md_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(negedge clk);
    md_start = 1'b0; src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bc);
    logic got;
    got = 1'b0;
    lat = 0;
    bc  = int'(md_busy);
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (md_done) got = 1'b1;
      else if (md_busy) bc++;
    end
    if (!got) lat = -1;
  endtask

  logic [3:0]  t_op  [14] = '{4'd0, 4'd10, 4'd5, 4'd1, 4'd8, 4'd3, 4'd4, 4'd9, 4'd12, 4'd11,
                              4'd13, 4'd7, 4'd2, 4'd6};
  logic [31:0] t_a   [14] = '{32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'h4, 32'h4,
                              32'h24, 32'h0, 32'h0, 32'h0, 32'h5, 32'hF0F0, 32'hF000, 32'hFF00};
  logic [31:0] t_b   [14] = '{32'h1, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'hF000_0000, 32'hF000_0000,
                              32'h1, 32'h8001, 32'h1234_ABCD, 32'h0, 32'h6, 32'hFF00, 32'h000F,
                              32'h0F0F};
  logic [31:0] t_exp [14] = '{32'h8000_0000, 32'h1, 32'h1, 32'h7FFF_FFFF, 32'hFF00_0000,
                              32'h0F00_0000, 32'h10, 32'hFFFF_8001, 32'hABCD_0000, 32'hFFFF_FFFF,
                              32'h0, 32'h0FF0, 32'hF00F, 32'h0F00};
  logic        t_ovf [14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int          lat, bc, dones;
    logic        mv;
    rst_n = 1'b0;
    src_a = '0; src_b = '0; alu_op = '0; md_start = 1'b0; md_op = '0; md_flush = 1'b0;
    s_a = '0; s_b = '0; s_alu_op = '0; s_start = 1'b0; s_op = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(md_busy), 64'h0);
    check("rst_done", 64'(md_done), 64'h0);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst16_busy", 64'(s_busy), 64'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Pin the reference model against hand-computed values.
    check("model_mult", md_model(3'd0, 32'hFFFF_FFFE, 32'h3), 64'hFFFF_FFFF_FFFF_FFFA);
    check("model_div", md_model(3'd2, 32'hFFFF_FFF9, 32'h2), 64'hFFFF_FFFF_FFFF_FFFD);
    check("model_divmin", md_model(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
    check("model_slt", 64'(alu_model(4'd5, 32'h8000_0000, 32'h1, mv)), 64'h1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      alu_op = t_op[i]; src_a = t_a[i]; src_b = t_b[i];
      #1;
      check($sformatf("alu_vec%0d", i), 64'(alu_out), 64'(t_exp[i]));
      check($sformatf("ovf_vec%0d", i), 64'(ovf), 64'(t_ovf[i]));
    end

    md_issue(3'd0, 32'hFFFF_FFFE, 32'h3);
    wait_done(lat, bc);
    check("mult_latency", 64'(lat), 64'd33);
    check("mult_busy_cycles", 64'(bc), 64'd33);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    md_issue(3'd2, 32'hFFFF_FFF9, 32'h2);
    wait_done(lat, bc);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    md_issue(3'd3, 32'h7, 32'h0);
    wait_done(lat, bc);
    check("divu0_latency", 64'(lat), 64'd33);
    check("divu0_hi", 64'(hi), 64'h7);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);

    md_issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    md_start = 1'b1; md_op = 3'd1; src_a = 32'h5; src_b = 32'h5;
    @(negedge clk);
    md_start = 1'b0;
    wait_done(lat, bc);
    check("divmin_latency_after_ignored_start", 64'(lat), 64'd27);
    check("divmin_hi", 64'(hi), 64'h0);
    check("divmin_lo", 64'(lo), 64'h8000_0000);
    @(negedge clk);
    check("no_restart_busy", 64'(md_busy), 64'h0);

    md_issue(3'd6, 32'hAAAA_AAAA, 32'h1);
    check("reserved_busy", 64'(md_busy), 64'h0);
    check("reserved_hi", 64'(hi), 64'h0);

    md_issue(3'd4, 32'h1234, 32'h0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_done", 64'(md_done), 64'h0);
    check("mthi_busy", 64'(md_busy), 64'h0);

    md_issue(3'd1, 32'hFFFF, 32'hFFFF);
    repeat (8) @(negedge clk);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    check("flush_busy", 64'(md_busy), 64'h0);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (md_done) dones++;
    end
    check("flush_no_done", 64'(dones), 64'h0);
    check("flush_hi", 64'(hi), 64'h1234);
    check("flush_lo", 64'(lo), 64'h8000_0000);

    @(negedge clk);
    md_start = 1'b1; md_op = 3'd5; src_a = 32'hDEAD; md_flush = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_flush = 1'b0;
    check("flush_beats_mtlo", 64'(lo), 64'h8000_0000);

    md_issue(3'd2, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(md_busy), 64'h0);
    check("async_rst_hi", 64'(hi), 64'h0);
    check("async_rst_lo", 64'(lo), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    s_alu_op = 4'd0; s_a = 16'h7FFF; s_b = 16'h1;
    #1;
    check("alu16_add", 64'(s_alu), 64'h8000);
    check("alu16_ovf", 64'(s_ovf), 64'h1);
    @(negedge clk);
    s_start = 1'b1; s_op = 3'd0; s_a = 16'hFFFE; s_b = 16'h3;
    @(negedge clk);
    s_start = 1'b0; s_a = 16'h0; s_b = 16'h0;
    lat = 0;
    while (lat >= 0 && !s_done) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 100) lat = -1;
    end
    check("mult16_latency", 64'(lat), 64'd9);
    check("mult16_hi", 64'(s_hi), 64'hFFFF);
    check("mult16_lo", 64'(s_lo), 64'hFFFA);
    check("mult16_busy_after", 64'(s_busy), 64'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
